// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back data cache controller: 8 lines of 4 bytes, one
// outstanding miss, optional dirty-victim writeback followed by a block fetch.
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state_reg, state_next;
  logic        valid_reg [8];
  logic        dirty_reg [8];
  logic [2:0]  tag_reg   [8];
  logic [31:0] data_reg  [8];

  logic [2:0]  addr_tag, addr_idx;
  logic [1:0]  addr_off;
  logic [2:0]  line_tag;
  logic [31:0] line_data;
  logic        line_valid, line_dirty, hit, request;
  logic        write_hit, fill, wb_done;

  assign addr_tag   = ADDRESS[7:5];
  assign addr_idx   = ADDRESS[4:2];
  assign addr_off   = ADDRESS[1:0];
  assign line_tag   = tag_reg[addr_idx];
  assign line_data  = data_reg[addr_idx];
  assign line_valid = valid_reg[addr_idx];
  assign line_dirty = dirty_reg[addr_idx];
  assign hit        = line_valid && (line_tag == addr_tag);
  assign request    = READ || WRITE;

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    READDATA      = 8'd0;
    write_hit     = 1'b0;
    fill          = 1'b0;
    wb_done       = 1'b0;
    case (state_reg)
      IDLE: begin
        BUSYWAIT  = request && !hit;
        write_hit = WRITE && hit;
        if (READ && hit) READDATA = line_data[{addr_off, 3'b000} +: 8];
        if (request && !hit)
          state_next = (line_valid && line_dirty) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {line_tag, addr_idx};
        MEM_WRITEDATA = line_data;
        BUSYWAIT      = 1'b1;
        if (!MEM_BUSYWAIT) begin
          wb_done    = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_idx};
        BUSYWAIT    = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-line state: only valid/dirty are reset, tag and data come up unknown.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      logic sel;
      assign sel = (addr_idx == 3'(gi));

      always_ff @(posedge CLK) begin
        if (RESET) begin
          valid_reg[gi] <= 1'b0;
          dirty_reg[gi] <= 1'b0;
        end else if (fill && sel) begin
          valid_reg[gi] <= 1'b1;
          dirty_reg[gi] <= 1'b0;
        end else if (wb_done && sel) begin
          dirty_reg[gi] <= 1'b0;
        end else if (write_hit && sel) begin
          dirty_reg[gi] <= 1'b1;
        end
      end

      always_ff @(posedge CLK) begin
        if (fill && sel) begin
          tag_reg[gi]  <= addr_tag;
          data_reg[gi] <= MEM_READDATA;
        end else if (write_hit && sel) begin
          data_reg[gi][{addr_off, 3'b000} +: 8] <= WRITEDATA;
        end
      end
    end
  endgenerate

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache between the CPU datapath and the 32-bit-block data memory.
- Sits directly downstream of reg_file. OUT1 of reg_file supplies WRITEDATA for stores. READDATA feeds the reg_file IN mux for loads.
- BUSYWAIT stalls the PC and reg_file writes while a miss is serviced.

Parameters:
- BLOCKS, 8, number of cache lines; fixed by the address split (index = ADDRESS[4:2]).
- BLOCK_BYTES, 4, bytes per line; fixed (offset = ADDRESS[1:0]).

Ports:
- CLK  input  1  system clock; all state changes on posedge
- RESET  input  1  synchronous, active-high reset
- READ  input  1  CPU load request
- WRITE  input  1  CPU store request
- ADDRESS  input  8  byte address: tag[7:5], index[4:2], offset[1:0]
- WRITEDATA  input  8  store data (from reg_file OUT1)
- READDATA  output  8  load data (to reg_file IN mux)
- BUSYWAIT  output  1  stall request to CPU
- MEM_READ  output  1  memory block read strobe
- MEM_WRITE  output  1  memory block write strobe
- MEM_ADDRESS  output  6  block address {tag,index}
- MEM_WRITEDATA  output  32  victim block, byte0 in [7:0]
- MEM_READDATA  input  32  fetched block, byte0 in [7:0]
- MEM_BUSYWAIT  input  1  memory busy; low in the cycle a transfer completes

Behaviour:
- Clocking and reset:
  - One clock: CLK.
  - Reset is synchronous and active-high: RESET sampled on posedge CLK.
  - At reset: all valid and dirty bits cleared, state=IDLE.
  - Tag and data arrays are not reset.
- Outputs one cycle after a reset edge: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
- Storage: 8 lines, each with valid, dirty, 3-bit tag and 32-bit data.
- Hit = valid[index] & (tag[index]==ADDRESS[7:5]). Hit is combinational.
- Request = READ | WRITE. READ and WRITE together is illegal; WRITE takes priority.
- State machine: IDLE, WRITEBACK, FETCH. Outputs are Moore except BUSYWAIT and READDATA in IDLE.
- IDLE:
  - BUSYWAIT = request & !hit.
  - Read hit: READDATA = selected byte of the line, combinational, zero added latency. READDATA=0 when !READ or !hit.
  - Write hit: at posedge, byte[offset] <= WRITEDATA, dirty <= 1; BUSYWAIT stays 0.
  - Miss with victim invalid or clean -> FETCH.
  - Miss with victim valid & dirty -> WRITEBACK.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=line data, BUSYWAIT=1.
  - Leave on the posedge where MEM_BUSYWAIT=0: -> FETCH, dirty[index] <= 0.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}, BUSYWAIT=1.
  - On the posedge where MEM_BUSYWAIT=0: data <= MEM_READDATA, tag <= ADDRESS[7:5], valid <= 1, dirty <= 0; -> IDLE.
- After a fill, the retried access hits in IDLE the next cycle. A store miss therefore costs fetch + 1 cycle, and the dirty bit is set on the hit cycle.
- MEM_READ and MEM_WRITE are never asserted together. Each strobe is held continuously until completion.
- The address/request is not re-sampled during WRITEBACK/FETCH; the CPU holds it stable while BUSYWAIT=1. If the request drops mid-miss, the transfer still completes and the line is installed.
- Reset mid-miss: at the reset edge, strobes drop and the state returns to IDLE with all lines invalid. Memory must tolerate an abandoned transfer.
- Index wrap: 8'hFF maps to index 7, offset 3, tag 7; 8'h00 maps to line 0, offset 0.

Test Plan:
- Memory model: MEM_BUSYWAIT high for 4 cycles after a strobe rises, then low for 1 cycle.
- Reset, then READ 8'h04 with memory block 1 = 32'hDDCCBBAA:
  - BUSYWAIT=1 immediately; MEM_READ=1, MEM_ADDRESS=6'h01.
  - Line installs after 5 cycles; next cycle BUSYWAIT=0, READDATA=8'hAA.
  - READ 8'h07 -> 8'hDD with no stall.
- WRITE 8'h05 = 8'h5A (hit on line 1) -> no stall, no memory strobe; READ 8'h05 -> 8'h5A.
- Then READ 8'h24 (same index, tag 1, dirty victim):
  - WRITEBACK: MEM_ADDRESS=6'h01, MEM_WRITEDATA=32'hDDCC5AAA.
  - Then FETCH: MEM_ADDRESS=6'h09.
  - MEM_READ and MEM_WRITE never both high.
- Clean-victim miss (READ 8'h44 after the line-1 fill) -> FETCH only, no MEM_WRITE pulse.
- Assert RESET during the 2nd FETCH cycle:
  - The next cycle has all strobes 0, BUSYWAIT=0 when idle.
  - A subsequent READ 8'h04 misses again.
- READ and WRITE high together on a hit: the store occurs and READDATA is ignored.
- READ 8'hFF after fill of block 6'h3F = 32'h11223344 -> READDATA=8'h11.
